// File: rtl/swap_ctrl_fsm.sv
// Memory swapper control FSM: exchanges the contents of two RAM locations
// on a start pulse and passes the user port through to the RAM when idle.
module swap_ctrl_fsm #(
    parameter int addr_w_N    = 7,
    parameter int data_w_Bits = 8,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [addr_w_N-1:0]    addr_a_in,
    input  logic [addr_w_N-1:0]    addr_b_in,
    input  logic                   user_we,
    input  logic [data_w_Bits-1:0] user_wr_data,
    input  logic [data_w_Bits-1:0] rd_data,
    output logic [addr_w_N-1:0]    address_A,
    output logic [addr_w_N-1:0]    address_B,
    output logic [1:0]             sel_r,
    output logic [1:0]             sel_w,
    output logic                   we,
    output logic [data_w_Bits-1:0] wr_data,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       swap_count
);

    // Mux select encodings shared by the read and write address muxes.
    localparam logic [1:0] SEL_USER = 2'd0;
    localparam logic [1:0] SEL_A    = 2'd1;
    localparam logic [1:0] SEL_B    = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_CAP_B,
        S_WR_A,
        S_WR_B,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [addr_w_N-1:0]      addr_a_q, addr_a_d;
    logic [addr_w_N-1:0]      addr_b_q, addr_b_d;
    logic [data_w_Bits-1:0]   tmp_a_q, tmp_a_d;
    logic [data_w_Bits-1:0]   tmp_b_q, tmp_b_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tmp_a_q  <= '0;
            tmp_b_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            tmp_a_q  <= tmp_a_d;
            tmp_b_q  <= tmp_b_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic plus address latching, word capture and swap counting.
    always_comb begin
        state_d  = state_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        tmp_a_d  = tmp_a_q;
        tmp_b_d  = tmp_b_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_a_d = addr_a_in;
                    addr_b_d = addr_b_in;
                    // Swapping a location with itself is a no-op: skip RAM access.
                    state_d  = (addr_a_in == addr_b_in) ? S_DONE : S_RD_A;
                end
            end
            S_RD_A:  state_d = S_RD_B;
            S_RD_B: begin
                // Synchronous RAM: data for the A address issued in RD_A arrives now.
                tmp_a_d = rd_data;
                state_d = S_CAP_B;
            end
            S_CAP_B: begin
                tmp_b_d = rd_data;
                state_d = S_WR_A;
            end
            S_WR_A:  state_d = S_WR_B;
            S_WR_B:  state_d = S_DONE;
            S_DONE: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode; IDLE forwards the user write port combinationally.
    always_comb begin
        sel_r   = SEL_USER;
        sel_w   = SEL_USER;
        we      = 1'b0;
        wr_data = '0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy    = 1'b0;
                we      = user_we;
                wr_data = user_wr_data;
            end
            S_RD_A:  sel_r = SEL_A;
            S_RD_B:  sel_r = SEL_B;
            S_CAP_B: sel_r = SEL_USER;
            S_WR_A: begin
                sel_w   = SEL_A;
                we      = 1'b1;
                wr_data = tmp_b_q;
            end
            S_WR_B: begin
                sel_w   = SEL_B;
                we      = 1'b1;
                wr_data = tmp_a_q;
            end
            S_DONE:  done = 1'b1;
            default: busy = 1'b1;
        endcase
    end

    assign address_A  = addr_a_q;
    assign address_B  = addr_b_q;
    assign swap_count = cnt_q;

endmodule
